// File: rtl/oxi_pkg.sv
// oxi_pkg: shared phase enum, channel tags and front-end reset constants.
package oxi_pkg;
    typedef enum logic [1:0] {IDLE, RED, IR, AMB} phase_t;
    localparam logic [1:0] CH_RED = 2'd0;
    localparam logic [1:0] CH_IR  = 2'd1;
    localparam logic [1:0] CH_AMB = 2'd2;
    localparam logic [6:0] DC_RESET  = 7'd127;
    localparam logic [3:0] PGA_RESET = 4'd0;
endpackage

// File: rtl/led_phase_scheduler_if.sv
// led_phase_scheduler_if: control, config, ADC, front-end and result handshake bundle.
// master drives enable/cfg/adc/sample_ready; slave (scheduler) drives LEDs,
// DC/PGA settings, sample_data/ch/valid, overrun and busy.
interface led_phase_scheduler_if;
    logic       enable;
    logic       cfg_load;
    logic [6:0] red_dc;
    logic [6:0] ir_dc;
    logic [3:0] red_pga;
    logic [3:0] ir_pga;
    logic [7:0] adc;
    logic       led_red;
    logic       led_ir;
    logic [6:0] dc_comp;
    logic [3:0] pga_gain;
    logic [7:0] sample_data;
    logic [1:0] sample_ch;
    logic       sample_valid;
    logic       sample_ready;
    logic       overrun;
    logic       busy;
    modport master (
        output enable, cfg_load, red_dc, ir_dc, red_pga, ir_pga, adc, sample_ready,
        input  led_red, led_ir, dc_comp, pga_gain, sample_data, sample_ch, sample_valid, overrun, busy
    );
    modport slave (
        input  enable, cfg_load, red_dc, ir_dc, red_pga, ir_pga, adc, sample_ready,
        output led_red, led_ir, dc_comp, pga_gain, sample_data, sample_ch, sample_valid, overrun, busy
    );
endinterface

// File: rtl/phase_accum.sv
// phase_accum: per-phase settle counter, ADC accumulator and averaging divide.
// Ports: clk, rst (async, active-high); active_i high while a phase runs;
// adc_i sample; done_o pulses on the last phase cycle with result_o = average.
module phase_accum #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOG2_AVG      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active_i,
    input  logic [7:0] adc_i,
    output logic       done_o,
    output logic [7:0] result_o
);
    localparam int PL = SETTLE_CYCLES + (1 << LOG2_AVG);
    localparam int CW = $clog2(PL);
    localparam int AW = 8 + LOG2_AVG;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d, sum;
    // The last sample is folded into the result combinationally, so the
    // accumulator can clear on the same edge the next phase begins.
    always_comb begin
        sum      = acc_q + AW'(adc_i);
        done_o   = active_i && cnt_q == CW'(PL - 1);
        result_o = 8'(sum >> LOG2_AVG);
        cnt_d    = (!active_i || done_o) ? '0 : cnt_q + CW'(1);
        acc_d    = (!active_i || done_o) ? '0 : (cnt_q >= CW'(SETTLE_CYCLES)) ? sum : acc_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/led_phase_scheduler.sv
// led_phase_scheduler: cycles LED phases RED -> IR (-> AMB) and emits averaged ADC results.
// Ports: clk, rst (async, active-high); bus (led_phase_scheduler_if.slave).
// Build option: define LED_PHASE_AMBIENT_EN to insert the AMB phase after IR.
module led_phase_scheduler
    import oxi_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOG2_AVG      = 2
) (
    input logic clk,
    input logic rst,
    led_phase_scheduler_if.slave bus
);
`ifdef LED_PHASE_AMBIENT_EN
    localparam phase_t AFTER_IR = AMB;
`else
    localparam phase_t AFTER_IR = RED;
`endif
    phase_t     state_q, state_d;
    logic [6:0] red_dc_q, red_dc_d, ir_dc_q, ir_dc_d, dc_q, dc_d;
    logic [3:0] red_pga_q, red_pga_d, ir_pga_q, ir_pga_d, pga_q, pga_d;
    logic [7:0] data_q, data_d, result;
    logic [1:0] ch_q, ch_d;
    logic       valid_q, valid_d, ovr_q, ovr_d, cfg_ok, done;
    phase_accum #(.SETTLE_CYCLES(SETTLE_CYCLES), .LOG2_AVG(LOG2_AVG)) u_accum (
        .clk      (clk),
        .rst      (rst),
        .active_i (state_q != IDLE),
        .adc_i    (bus.adc),
        .done_o   (done),
        .result_o (result)
    );
    always_comb begin
        cfg_ok    = state_q == IDLE && bus.cfg_load;
        red_dc_d  = cfg_ok ? bus.red_dc : red_dc_q;
        red_pga_d = cfg_ok ? bus.red_pga : red_pga_q;
        ir_dc_d   = cfg_ok ? bus.ir_dc : ir_dc_q;
        ir_pga_d  = cfg_ok ? bus.ir_pga : ir_pga_q;
        state_d   = state_q;
        if (state_q == IDLE)
            state_d = bus.enable ? RED : IDLE;
        else if (done)
            state_d = !bus.enable ? IDLE : state_q == RED ? IR : state_q == IR ? AFTER_IR : RED;
        // Front-end settings are latched with the state so they change on phase entry;
        // using the _d copies lets a same-cycle cfg_load take effect immediately.
        dc_d    = state_d == IR ? ir_dc_d : state_d == IDLE ? dc_q : red_dc_d;
        pga_d   = state_d == IR ? ir_pga_d : state_d == IDLE ? pga_q : red_pga_d;
        data_d  = done ? result : data_q;
        ch_d    = !done ? ch_q : state_q == IR ? CH_IR : state_q == AMB ? CH_AMB : CH_RED;
        valid_d = done ? 1'b1 : bus.sample_ready ? 1'b0 : valid_q;
        ovr_d   = cfg_ok ? 1'b0 : (done && valid_q && !bus.sample_ready) ? 1'b1 : ovr_q;
        bus.led_red      = state_q == RED;
        bus.led_ir       = state_q == IR;
        bus.busy         = state_q != IDLE;
        bus.dc_comp      = dc_q;
        bus.pga_gain     = pga_q;
        bus.sample_data  = data_q;
        bus.sample_ch    = ch_q;
        bus.sample_valid = valid_q;
        bus.overrun      = ovr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            red_dc_q  <= DC_RESET;
            ir_dc_q   <= DC_RESET;
            dc_q      <= DC_RESET;
            red_pga_q <= PGA_RESET;
            ir_pga_q  <= PGA_RESET;
            pga_q     <= PGA_RESET;
            data_q    <= '0;
            ch_q      <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            red_dc_q  <= red_dc_d;
            ir_dc_q   <= ir_dc_d;
            dc_q      <= dc_d;
            red_pga_q <= red_pga_d;
            ir_pga_q  <= ir_pga_d;
            pga_q     <= pga_d;
            data_q    <= data_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end
endmodule

// File: tb/tb_led_phase_scheduler.sv
// tb_led_phase_scheduler: scoreboard bench for led_phase_scheduler (default parameters).
module tb_led_phase_scheduler;
    logic clk;
    logic rst;
    int n_tot = 0;
    int n_bad = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    led_phase_scheduler_if bus();
    led_phase_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Runs one 8-cycle phase (4 settle + 4 averaged). ch selects expected LEDs;
    // settle cycles drive 255 so any settle-window sample would corrupt the average.
    task automatic do_phase(input int ch, input int s0, input int s1, input int s2, input int s3,
                            input int edc, input int epga, input int drop_at, input bit push);
        int s[4];
        int avg;
        s = '{s0, s1, s2, s3};
        avg = (s0 + s1 + s2 + s3) >> 2;
        if (push) exp_q.push_back({2'(ch), 8'(avg)});
        for (int k = 0; k < 8; k++) begin
            chk("led_red", int'(bus.led_red), int'(ch == 0));
            chk("led_ir", int'(bus.led_ir), int'(ch == 1));
            chk("busy", int'(bus.busy), 1);
            if (k == 0) begin
                chk("dc_comp", int'(bus.dc_comp), edc);
                chk("pga_gain", int'(bus.pga_gain), epga);
            end
            if (k == drop_at) bus.enable = 1'b0;
            bus.adc = (k < 4) ? 8'd255 : 8'(s[k-4]);
            tick();
            bus.cfg_load = 1'b0;
        end
        chk("valid_on_time", int'(bus.sample_valid), 1);
        chk("data_on_time", int'(bus.sample_data), avg);
        chk("ch_on_time", int'(bus.sample_ch), ch);
    endtask
    always @(negedge clk) begin
        if (bus.sample_valid && bus.sample_ready) begin
            if (exp_q.size() == 0) chk("spurious_result", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("sb_data", int'(bus.sample_data), int'(mon_e[7:0]));
                chk("sb_ch", int'(bus.sample_ch), int'(mon_e[9:8]));
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.cfg_load = 1'b0;
        bus.red_dc = '0;
        bus.ir_dc = '0;
        bus.red_pga = '0;
        bus.ir_pga = '0;
        bus.adc = '0;
        bus.sample_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led_red", int'(bus.led_red), 0);
        chk("rst_led_ir", int'(bus.led_ir), 0);
        chk("rst_dc", int'(bus.dc_comp), 127);
        chk("rst_pga", int'(bus.pga_gain), 0);
        chk("rst_data", int'(bus.sample_data), 0);
        chk("rst_ch", int'(bus.sample_ch), 0);
        chk("rst_valid", int'(bus.sample_valid), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        tick();
        // Config and enable together: RED starts with the freshly loaded values.
        bus.red_dc = 7'd40;
        bus.red_pga = 4'd3;
        bus.ir_dc = 7'd30;
        bus.ir_pga = 4'd5;
        bus.cfg_load = 1'b1;
        bus.enable = 1'b1;
        tick();
        bus.cfg_load = 1'b0;
        do_phase(0, 100, 100, 100, 100, 40, 3, -1, 1);
        do_phase(1, 100, 100, 100, 100, 30, 5, -1, 1);
`ifdef LED_PHASE_AMBIENT_EN
        do_phase(2, 100, 100, 100, 100, 40, 3, -1, 1);
`endif
        do_phase(0, 10, 20, 30, 40, 40, 3, -1, 1);
        do_phase(1, 7, 9, 11, 13, 30, 5, 2, 1);
        chk("idle_led_red", int'(bus.led_red), 0);
        chk("idle_led_ir", int'(bus.led_ir), 0);
        chk("idle_busy", int'(bus.busy), 0);
        tick();
        // Overrun: two results without ready; cfg_load outside IDLE must be ignored.
        bus.sample_ready = 1'b0;
        bus.enable = 1'b1;
        tick();
        bus.red_dc = 7'd99;
        bus.ir_dc = 7'd99;
        bus.red_pga = 4'd9;
        bus.ir_pga = 4'd9;
        bus.cfg_load = 1'b1;
        do_phase(0, 50, 50, 50, 50, 40, 3, -1, 0);
        do_phase(1, 60, 60, 60, 60, 30, 5, 0, 1);
        chk("ovr_set", int'(bus.overrun), 1);
        chk("ovr_valid_held", int'(bus.sample_valid), 1);
        bus.sample_ready = 1'b1;
        tick();
        chk("valid_cleared", int'(bus.sample_valid), 0);
        chk("ovr_sticky", int'(bus.overrun), 1);
        bus.red_dc = 7'd40;
        bus.red_pga = 4'd3;
        bus.ir_dc = 7'd30;
        bus.ir_pga = 4'd5;
        bus.cfg_load = 1'b1;
        tick();
        bus.cfg_load = 1'b0;
        chk("ovr_cleared", int'(bus.overrun), 0);
        // Asynchronous reset with two samples accumulated in RED.
        bus.enable = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("pre_rst_led_red", int'(bus.led_red), 1);
            bus.adc = (k < 4) ? 8'd255 : 8'd100;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_led_red", int'(bus.led_red), 0);
        chk("arst_dc", int'(bus.dc_comp), 127);
        chk("arst_pga", int'(bus.pga_gain), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_valid", int'(bus.sample_valid), 0);
        chk("arst_data", int'(bus.sample_data), 0);
        #1 rst = 1'b0;
        tick();
        do_phase(0, 200, 200, 200, 200, 127, 0, 0, 1);
        chk("end_busy", int'(bus.busy), 0);
        repeat (3) tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
